// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/status bundle between the multicycle controller and its datapath
interface multicycle_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [3:0] alucont;
   logic       signext;
   logic       shiftl16;
   logic       illegal;
   logic [3:0] state;
   modport master (
      input  op, funct, zero,
      output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, alucont, signext, shiftl16, illegal, state
   );
   modport slave (
      output op, funct, zero,
      input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, alucont, signext, shiftl16, illegal, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM sequencing a shared-ALU, single-memory multicycle MIPS datapath
module multicycle_ctrl #(
   parameter int MEM_WAIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      RTYPEEX, RTYPEWB, BREX, IMMEX, IMMWB, JEX
   } state_t;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1111;
   state_t     state_q, state_n;
   logic [3:0] cnt_q;
   logic       last;
   logic       is_sw_q, is_bne_q, imm_or_q, imm_lui_q;
   logic       pcwrite, branch, irwrite_i, memwrite_i, regwrite_i, illegal_i;
   logic       op_ok, funct_ok;
   assign last     = cnt_q == 4'(MEM_WAIT);
   assign op_ok    = bus.op inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
                                    OP_ORI, OP_LUI, OP_LW, OP_SW};
   assign funct_ok = bus.funct inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                       6'b100100, 6'b100101, 6'b101010, 6'b101011};
   // state register; wait counter restarts whenever the state changes
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= (state_n != state_q) ? '0 : cnt_q + 4'd1;
      end
   end
   // capture the opcode class in DECODE so later states do not depend on op
   always_ff @(posedge clk) begin
      if (reset) begin
         is_sw_q   <= 1'b0;
         is_bne_q  <= 1'b0;
         imm_or_q  <= 1'b0;
         imm_lui_q <= 1'b0;
      end else if (state_q == DECODE) begin
         is_sw_q   <= bus.op == OP_SW;
         is_bne_q  <= bus.op[0];
         imm_or_q  <= bus.op == OP_ORI || bus.op == OP_LUI;
         imm_lui_q <= bus.op == OP_LUI;
      end
   end
   // next-state and Moore outputs; selects hold through memory waits, strobes only on the last cycle
   always_comb begin
      state_n      = FETCH;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      irwrite_i    = 1'b0;
      memwrite_i   = 1'b0;
      regwrite_i   = 1'b0;
      illegal_i    = 1'b0;
      bus.iord     = 1'b0;
      bus.regdst   = 1'b0;
      bus.memtoreg = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = 2'b00;
      bus.pcsrc    = 2'b00;
      bus.alucont  = ALU_ADD;
      bus.signext  = 1'b1;
      bus.shiftl16 = 1'b0;
      case (state_q)
         FETCH: begin
            bus.alusrcb = 2'b01;
            irwrite_i   = last;
            pcwrite     = last;
            state_n     = last ? DECODE : FETCH;
         end
         DECODE: begin
            bus.alusrcb = 2'b11;
            illegal_i   = !op_ok || (bus.op == OP_RTYPE && !funct_ok);
            state_n     = illegal_i ? FETCH :
                          (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                          bus.op == OP_RTYPE ? RTYPEEX :
                          (bus.op == OP_BEQ || bus.op == OP_BNE) ? BREX :
                          bus.op == OP_J ? JEX : IMMEX;
         end
         MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            state_n     = is_sw_q ? MEMWR : MEMRD;
         end
         MEMRD: begin
            bus.iord = 1'b1;
            state_n  = last ? MEMWB : MEMRD;
         end
         MEMWB: begin
            bus.memtoreg = 1'b1;
            regwrite_i   = 1'b1;
         end
         MEMWR: begin
            bus.iord   = 1'b1;
            memwrite_i = last;
            state_n    = last ? FETCH : MEMWR;
         end
         RTYPEEX: begin
            bus.alusrca = 1'b1;
            bus.alucont = bus.funct[3] ? (bus.funct[0] ? ALU_SLTU : ALU_SLT) :
                          bus.funct[2] ? (bus.funct[0] ? ALU_OR : ALU_AND) :
                          bus.funct[1] ? ALU_SUB : ALU_ADD;
            state_n     = RTYPEWB;
         end
         RTYPEWB: begin
            bus.regdst = 1'b1;
            regwrite_i = 1'b1;
         end
         BREX: begin
            bus.alusrca = 1'b1;
            bus.alucont = ALU_SUB;
            bus.pcsrc   = 2'b01;
            branch      = 1'b1;
         end
         IMMEX: begin
            bus.alusrca  = 1'b1;
            bus.alusrcb  = 2'b10;
            bus.alucont  = imm_or_q ? ALU_OR : ALU_ADD;
            bus.signext  = !imm_or_q;
            bus.shiftl16 = imm_lui_q;
            state_n      = IMMWB;
         end
         IMMWB: regwrite_i = 1'b1;
         JEX: begin
            bus.pcsrc = 2'b10;
            pcwrite   = 1'b1;
         end
         default: state_n = FETCH;
      endcase
   end
   assign bus.pcen     = !reset && (pcwrite || (branch && (bus.zero ^ is_bne_q)));
   assign bus.irwrite  = !reset && irwrite_i;
   assign bus.memwrite = !reset && memwrite_i;
   assign bus.regwrite = !reset && regwrite_i;
   assign bus.illegal  = !reset && illegal_i;
   assign bus.state    = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized check of the multicycle controller against a per-instruction cycle model
module tb_multicycle_ctrl;
   typedef struct packed {
      logic [3:0] st;
      logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic [3:0] alucont;
      logic       signext, shiftl16, illegal;
   } cyc_t;
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
   localparam logic [5:0] LUI = 6'b001111, ORI = 6'b001101, ADDI = 6'b001000, ADDIU = 6'b001001;
   localparam logic [5:0] JMP = 6'b000010, RT = 6'b000000;
   logic clk = 1'b0, r0 = 1'b1, r2 = 1'b1;
   int   errors = 0, checks = 0, cur = -1;
   cyc_t exp_q[$];
   cyc_t a0, a2;
   multicycle_ctrl_if b0 ();
   multicycle_ctrl_if b2 ();
   multicycle_ctrl #(.MEM_WAIT(0)) u0 (.clk(clk), .reset(r0), .bus(b0));
   multicycle_ctrl #(.MEM_WAIT(2)) u2 (.clk(clk), .reset(r2), .bus(b2));
   always #5 clk = ~clk;
   always_comb a0 = '{st: b0.state, pcen: b0.pcen, iord: b0.iord, memwrite: b0.memwrite,
                      irwrite: b0.irwrite, regdst: b0.regdst, memtoreg: b0.memtoreg,
                      regwrite: b0.regwrite, alusrca: b0.alusrca, alusrcb: b0.alusrcb,
                      pcsrc: b0.pcsrc, alucont: b0.alucont, signext: b0.signext,
                      shiftl16: b0.shiftl16, illegal: b0.illegal};
   always_comb a2 = '{st: b2.state, pcen: b2.pcen, iord: b2.iord, memwrite: b2.memwrite,
                      irwrite: b2.irwrite, regdst: b2.regdst, memtoreg: b2.memtoreg,
                      regwrite: b2.regwrite, alusrca: b2.alusrca, alusrcb: b2.alusrcb,
                      pcsrc: b2.pcsrc, alucont: b2.alucont, signext: b2.signext,
                      shiftl16: b2.shiftl16, illegal: b2.illegal};
   function automatic cyc_t act(input int w);
      return w == 2 ? a2 : a0;
   endfunction
   function automatic cyc_t base(input logic [3:0] st);
      cyc_t c = '0;
      c.st = st;
      c.alucont = 4'b0010;
      c.signext = 1'b1;
      return c;
   endfunction
   function automatic logic [3:0] alu_of(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100001: return 4'b0010;
         6'b100010, 6'b100011: return 4'b0110;
         6'b100100:            return 4'b0000;
         6'b100101:            return 4'b0001;
         6'b101010:            return 4'b0111;
         default:              return 4'b1111;
      endcase
   endfunction
   task automatic drive(input int w, input logic [5:0] op, input logic [5:0] funct, input logic z);
      if (w == 2) begin
         b2.op = op; b2.funct = funct; b2.zero = z;
      end else begin
         b0.op = op; b0.funct = funct; b0.zero = z;
      end
   endtask
   task automatic build(input int w, input logic [5:0] op, input logic [5:0] funct, input logic z);
      int   wt = (w == 2) ? 2 : 0;
      cyc_t c;
      logic fok = funct inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                6'b100100, 6'b100101, 6'b101010, 6'b101011};
      logic ls = op inside {LW, SW};
      logic br = op inside {BEQ, BNE};
      logic im = op inside {ADDI, ADDIU, ORI, LUI};
      exp_q.delete();
      for (int i = 0; i <= wt; i++) begin
         c = base(0); c.alusrcb = 2'b01; c.irwrite = (i == wt); c.pcen = (i == wt);
         exp_q.push_back(c);
      end
      c = base(1); c.alusrcb = 2'b11;
      if (!(ls || br || im || op == JMP || (op == RT && fok))) begin
         c.illegal = 1'b1;
         exp_q.push_back(c);
         return;
      end
      exp_q.push_back(c);
      if (ls) begin
         c = base(2); c.alusrca = 1'b1; c.alusrcb = 2'b10; exp_q.push_back(c);
         for (int i = 0; i <= wt; i++) begin
            c = base(op == LW ? 4'd3 : 4'd5); c.iord = 1'b1; c.memwrite = (op == SW && i == wt);
            exp_q.push_back(c);
         end
         if (op == LW) begin
            c = base(4); c.memtoreg = 1'b1; c.regwrite = 1'b1; exp_q.push_back(c);
         end
      end else if (op == RT) begin
         c = base(6); c.alusrca = 1'b1; c.alucont = alu_of(funct); exp_q.push_back(c);
         c = base(7); c.regdst = 1'b1; c.regwrite = 1'b1; exp_q.push_back(c);
      end else if (br) begin
         c = base(8); c.alusrca = 1'b1; c.alucont = 4'b0110; c.pcsrc = 2'b01;
         c.pcen = (op == BNE) ? !z : z;
         exp_q.push_back(c);
      end else if (im) begin
         c = base(9); c.alusrca = 1'b1; c.alusrcb = 2'b10;
         if (op == ORI || op == LUI) begin
            c.alucont = 4'b0001; c.signext = 1'b0; c.shiftl16 = (op == LUI);
         end
         exp_q.push_back(c);
         c = base(10); c.regwrite = 1'b1; exp_q.push_back(c);
      end else begin
         c = base(11); c.pcsrc = 2'b10; c.pcen = 1'b1; exp_q.push_back(c);
      end
   endtask
   task automatic do_reset(input int w);
      r0 = 1'b1; r2 = 1'b1;
      @(posedge clk); @(negedge clk);
      if (w == 2) r2 = 1'b0; else r0 = 1'b0;
      cur = w;
   endtask
   task automatic run(input string name, input int w, input logic [5:0] op,
                      input logic [5:0] funct, input logic z);
      if (cur != w) do_reset(w);
      drive(w, op, funct, z);
      build(w, op, funct, z);
      #1;
      foreach (exp_q[i]) begin
         checks++;
         if (act(w) !== exp_q[i]) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, i, act(w), exp_q[i]);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask
   task automatic test_reset;
      drive(0, 6'($urandom), 6'($urandom), 1'($urandom));
      drive(2, 6'($urandom), 6'($urandom), 1'($urandom));
      @(posedge clk); @(negedge clk); #1;
      checks++;
      if (b0.state !== 4'd0 || b2.state !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d/%0d expected 0/0", b0.state, b2.state);
      end
      checks++;
      if ({b0.pcen, b0.irwrite, b0.memwrite, b0.regwrite, b0.illegal} !== 5'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b expected 00000",
                  {b0.pcen, b0.irwrite, b0.memwrite, b0.regwrite, b0.illegal});
      end
      checks++;
      if (b0.alusrcb !== 2'b01) begin
         errors++;
         $display("FAIL reset_alusrcb: got %b expected 01", b0.alusrcb);
      end
      @(negedge clk);
   endtask
   task automatic test_lw;
      run("lw", 0, LW, 6'($urandom), 1'($urandom));
   endtask
   task automatic test_branch;
      run("beq_z1", 0, BEQ, 6'($urandom), 1'b1);
      run("beq_z0", 0, BEQ, 6'($urandom), 1'b0);
      run("bne_z1", 0, BNE, 6'($urandom), 1'b1);
      run("bne_z0", 0, BNE, 6'($urandom), 1'b0);
      run("j", 0, JMP, 6'($urandom), 1'($urandom));
   endtask
   task automatic test_rtype;
      run("sltu", 0, RT, 6'b101011, 1'($urandom));
      run("sub", 0, RT, 6'b100010, 1'($urandom));
      run("bad_funct", 0, RT, 6'b000111, 1'($urandom));
   endtask
   task automatic test_imm;
      run("lui", 0, LUI, 6'($urandom), 1'($urandom));
      run("ori", 0, ORI, 6'($urandom), 1'($urandom));
      run("addi", 0, ADDI, 6'($urandom), 1'($urandom));
   endtask
   task automatic test_sw_wait;
      run("sw_wait", 2, SW, 6'($urandom), 1'($urandom));
      run("lw_wait", 2, LW, 6'($urandom), 1'($urandom));
   endtask
   task automatic test_reset_midwrite;
      do_reset(2);
      drive(2, SW, 6'($urandom), 1'($urandom));
      build(2, SW, 6'b0, 1'b0);
      #1;
      for (int i = 0; i <= 6; i++) begin
         checks++;
         if (a2 !== exp_q[i]) begin
            errors++;
            $display("FAIL midwr cycle %0d: got %h expected %h", i, a2, exp_q[i]);
         end
         if (i < 6) begin
            @(posedge clk); @(negedge clk); #1;
         end
      end
      r2 = 1'b1;
      #1;
      checks++;
      if (b2.state !== 4'd5 || {b2.pcen, b2.irwrite, b2.memwrite, b2.regwrite, b2.illegal} !== 5'b0) begin
         errors++;
         $display("FAIL midwr_reset_cycle: got state %0d strobes %b expected 5 00000", b2.state,
                  {b2.pcen, b2.irwrite, b2.memwrite, b2.regwrite, b2.illegal});
      end
      @(posedge clk); @(negedge clk); #1;
      checks++;
      if (b2.state !== 4'd0 || b2.memwrite !== 1'b0) begin
         errors++;
         $display("FAIL midwr_after: got state %0d memwrite %b expected 0 0", b2.state, b2.memwrite);
      end
      @(negedge clk);
      r2 = 1'b0;
      cur = 2;
      run("illegal_op", 2, 6'b111111, 6'($urandom), 1'($urandom));
   endtask
   task automatic test_random;
      logic [5:0] ops [12] = '{LW, SW, RT, RT, BEQ, BNE, ADDI, ADDIU, ORI, LUI, JMP, 6'b010001};
      logic [5:0] fns [8] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                              6'b100100, 6'b100101, 6'b101010, 6'b101011};
      logic [5:0] op, fn;
      for (int n = 0; n < 60; n++) begin
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
         fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
         run("random", $urandom_range(0, 1) ? 2 : 0, op, fn, 1'($urandom));
      end
   endtask
   initial begin
      test_reset;
      test_lw;
      test_branch;
      test_rtype;
      test_imm;
      test_sw_wait;
      test_reset_midwrite;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a shared-ALU, single-memory multicycle MIPS datapath.
- The datapath is built from the team's regfile, alu, sign_zero_ext, shift_left_16, flopenr and mux2/mux4 parts.
- Decodes op/funct and drives mux selects, ALU control, extender/shifter controls and all write enables, one instruction at a time.
- Optional memory wait states stretch the memory-access states.

Parameters:
MEM_WAIT, 0, extra cycles spent in each memory-access state (FETCH, MEMRD, MEMWR); legal range 0..15.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
op  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag
pcen  output  1  PC register enable
iord  output  1  memory address select: 0=PC, 1=ALUOut
memwrite  output  1  data memory write strobe
irwrite  output  1  instruction register enable
regdst  output  1  write address select: 0=rt, 1=rd
memtoreg  output  1  write data select: 0=ALUOut, 1=memdata
regwrite  output  1  register file we
alusrca  output  1  ALU A select: 0=PC, 1=rs data
alusrcb  output  2  ALU B select: 00=rt data, 01=constant 4, 10=extended imm, 11=extended imm<<2
pcsrc  output  2  next PC select: 00=ALU result, 01=ALUOut, 10=jump target
alucont  output  4  ALU control: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLTU 1111
signext  output  1  1=sign-extend imm, 0=zero-extend
shiftl16  output  1  shift extended imm left 16 (lui)
illegal  output  1  one-cycle pulse on an unsupported op/funct
state  output  4  current state, for debug/verification

Behaviour:
- Single clock domain. Reset is synchronous and active-high: at the clock edge with reset=1, state<=FETCH (0) and wait counter<=0.
- While reset=1, pcen, irwrite, memwrite, regwrite and illegal are forced to 0 combinationally.
- Defaults in every state unless listed: all enables 0, selects 0, alucont=0010, signext=1, shiftl16=0.
- pcen = pcwrite | (branch & (zero ^ isbne)).
- Wait counter counts 0..MEM_WAIT in the memory states; "final cycle" means counter==MEM_WAIT. The counter clears on any state change.
- In each memory state, select outputs are held stable for all wait cycles; strobes are asserted only on the final cycle.
- States and outputs:
  - FETCH(0): iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00. On the final cycle: irwrite=1, pcwrite=1, then go to DECODE. Otherwise stay.
  - DECODE(1): alusrca=0, alusrcb=11, ADD, signext=1 (branch target into ALUOut). Dispatch on op:
    - lw 100011 / sw 101011 -> MEMADR
    - R-type 000000 -> RTYPEEX
    - beq 000100 / bne 000101 -> BREX
    - addi 001000, addiu 001001, ori 001101, lui 001111 -> IMMEX
    - j 000010 -> JEX
    - any other op -> illegal=1, go to FETCH
  - R-type funct accepted: add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, slt 101010, sltu 101011. Any other funct -> illegal=1, go to FETCH.
  - MEMADR(2): alusrca=1, alusrcb=10, ADD, signext=1 -> MEMRD if lw, MEMWR if sw.
  - MEMRD(3): iord=1; on the final cycle go to MEMWB.
  - MEMWB(4): regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR(5): iord=1; memwrite=1 on the final cycle only, then go to FETCH.
  - RTYPEEX(6): alusrca=1, alusrcb=00, alucont by funct:
    - add/addu -> 0010
    - sub/subu -> 0110
    - and -> 0000, or -> 0001
    - slt -> 0111, sltu -> 1111
    - then go to RTYPEWB.
  - RTYPEWB(7): regdst=1, memtoreg=0, regwrite=1 -> FETCH.
  - BREX(8): alusrca=1, alusrcb=00, SUB, pcsrc=01, branch=1, isbne=op[0] -> FETCH.
  - IMMEX(9): alusrca=1, alusrcb=10 -> IMMWB.
    - addi/addiu: ADD, signext=1
    - ori: OR, signext=0
    - lui: OR, signext=0, shiftl16=1
  - IMMWB(10): regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JEX(11): pcsrc=10, pcwrite=1 -> FETCH.
  - Unused encodings 12-15: go to FETCH next cycle with all strobes 0.
- op/funct are sampled only in DECODE and RTYPEEX; the instruction register is stable after FETCH.
- Reset mid-instruction (e.g. during MEMWR wait cycles): no strobe fires in the reset cycle; next state is FETCH with counter 0.
- Cycle counts with MEM_WAIT=0: lw 5, sw 4, R-type 4, imm 4, branch 3, j 3. Each memory state adds MEM_WAIT cycles.

Test Plan:
- MEM_WAIT=0, lw (op=100011) after reset -> state 0,1,2,3,4,0. irwrite and pcen=1 in cycle 0 only; regwrite=1 and memtoreg=1 in state 4; alusrcb=10 in state 2.
- beq with zero=1 -> pcen=1, pcsrc=01 in BREX. bne with zero=1 -> pcen=0 in BREX. bne with zero=0 -> pcen=1.
- R-type: funct=101011 -> alucont=1111 in RTYPEEX, then regdst=1, regwrite=1. funct=000111 -> illegal pulse in DECODE, next state 0, no regwrite.
- lui (op=001111) -> IMMEX with shiftl16=1, signext=0, alucont=0001, alusrcb=10. ori -> signext=0, shiftl16=0.
- MEM_WAIT=2, sw -> FETCH 3 cycles with irwrite/pcen only on the 3rd; MEMWR 3 cycles, iord=1 throughout, memwrite only on the 3rd; total 8 cycles.
- MEM_WAIT=2, reset asserted in the 2nd MEMWR cycle -> memwrite never asserted. After release: state=0, full 3-cycle FETCH, op=111111 -> illegal=1 in DECODE, then FETCH.
